// File: rtl/vending_machine_def.sv
// ---------------------------------------------------------------------------
// vending_machine_def
//   Shared definitions for the vending machine change-return path.
//   Holds the money width, the coin denominations (index 0 is the smallest),
//   the change-dispense FSM state encoding, and a helper that maps a coin
//   index to its value.
// ---------------------------------------------------------------------------
package vending_machine_def;

  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 31;

  localparam logic [kTotalBits-1:0] kCoinVal0 = kTotalBits'(100);
  localparam logic [kTotalBits-1:0] kCoinVal1 = kTotalBits'(500);
  localparam logic [kTotalBits-1:0] kCoinVal2 = kTotalBits'(1000);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  // Value of coin denomination idx, zero-extended to the money width.
  // Any index outside the denomination table has value 0.
  function automatic logic [kTotalBits-1:0] coin_value(input int idx);
    logic [kTotalBits-1:0] v;
    v = '0;
    case (idx)
      0:       v = kCoinVal0;
      1:       v = kCoinVal1;
      2:       v = kCoinVal2;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_greedy_select.sv
// ---------------------------------------------------------------------------
// coin_greedy_select
//   Purely combinational greedy coin picker: chooses the largest denomination
//   whose value does not exceed the remaining amount.
//
// Ports:
//   i_remaining  [kTotalBits-1:0]  amount still to be returned
//   o_sel        [kNumCoins-1:0]   one-hot selected denomination (0 if none fits)
//   o_sel_value  [kTotalBits-1:0]  value of the selected coin (0 if none fits)
// ---------------------------------------------------------------------------
module coin_greedy_select
  import vending_machine_def::*;
(
  input  logic [kTotalBits-1:0] i_remaining,
  output logic [kNumCoins-1:0]  o_sel,
  output logic [kTotalBits-1:0] o_sel_value
);

  // Scan from the smallest coin upward and let later (larger) matches
  // overwrite earlier ones, which gives priority to the highest index.
  always_comb begin
    o_sel       = '0;
    o_sel_value = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_remaining >= coin_value(i)) begin
        o_sel       = '0;
        o_sel[i]    = 1'b1;
        o_sel_value = coin_value(i);
      end
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// change_dispense_ctrl
//   Returns change for the vending machine. On an accepted start it latches
//   the inserted total, asks the upstream total register to clear, and then
//   hands coins to the coin-return actuator one at a time (largest first)
//   over a valid/ready handshake. When nothing more can be represented in
//   coins it pulses done and reports the leftover amount.
//
// Ports:
//   clk            clock, rising edge
//   reset_n        synchronous active-low reset
//   i_start        return request (trigger or wait-time expiry), used in IDLE only
//   i_total        inserted total, sampled when the start is accepted
//   i_coin_ready   actuator accepts the presented coin
//   o_coin_valid   a coin is presented on o_coin_sel
//   o_coin_sel     one-hot denomination being returned
//   o_clear_total  one-cycle pulse clearing the upstream total register
//   o_busy         high whenever not IDLE
//   o_done         one-cycle completion pulse
//   o_residue      amount that could not be dispensed, held until next start
//   o_remaining    live amount still to be returned
// ---------------------------------------------------------------------------
module change_dispense_ctrl
  import vending_machine_def::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [kTotalBits-1:0] i_total,
  input  logic                  i_coin_ready,
  output logic                  o_coin_valid,
  output logic [kNumCoins-1:0]  o_coin_sel,
  output logic                  o_clear_total,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_residue,
  output logic [kTotalBits-1:0] o_remaining
);

  state_t                r_state;
  logic [kTotalBits-1:0] r_remaining;
  logic [kTotalBits-1:0] r_residue;
  logic                  r_clear_total;

  state_t                w_next_state;
  logic [kTotalBits-1:0] w_next_remaining;
  logic [kTotalBits-1:0] w_next_residue;
  logic                  w_next_clear_total;
  logic [kNumCoins-1:0]  w_sel;
  logic [kTotalBits-1:0] w_sel_value;
  logic [kTotalBits-1:0] w_after_coin;
  logic                  w_handshake;

  coin_greedy_select u_select (
    .i_remaining (r_remaining),
    .o_sel       (w_sel),
    .o_sel_value (w_sel_value)
  );

  // The greedy pick never exceeds r_remaining, so this cannot underflow.
  assign w_after_coin = r_remaining - w_sel_value;
  assign w_handshake  = o_coin_valid && i_coin_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_remaining   <= '0;
      r_residue     <= '0;
      r_clear_total <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_remaining   <= w_next_remaining;
      r_residue     <= w_next_residue;
      r_clear_total <= w_next_clear_total;
    end
  end

  // The residue is captured on the edge that enters DONE so it is already
  // valid while o_done is high, and is zeroed on every accepted start.
  always_comb begin
    w_next_state       = r_state;
    w_next_remaining   = r_remaining;
    w_next_residue     = r_residue;
    w_next_clear_total = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_remaining   = i_total;
          w_next_clear_total = 1'b1;
          if (i_total >= kCoinVal0) begin
            w_next_state   = ST_DISPENSE;
            w_next_residue = '0;
          end else begin
            w_next_state   = ST_DONE;
            w_next_residue = i_total;
          end
        end
      end
      ST_DISPENSE: begin
        if (w_handshake) begin
          w_next_remaining = w_after_coin;
          if (w_after_coin < kCoinVal0) begin
            w_next_state   = ST_DONE;
            w_next_residue = w_after_coin;
          end
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign o_coin_valid  = (r_state == ST_DISPENSE);
  assign o_coin_sel    = o_coin_valid ? w_sel : '0;
  assign o_clear_total = r_clear_total;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_residue     = r_residue;
  assign o_remaining   = r_remaining;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// tb_change_dispense_ctrl
//   Directed self-checking bench for change_dispense_ctrl. Inputs change and
//   outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_change_dispense_ctrl;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [30:0] i_total;
  logic        i_coin_ready;
  logic        o_coin_valid;
  logic [2:0]  o_coin_sel;
  logic        o_clear_total;
  logic        o_busy;
  logic        o_done;
  logic [30:0] o_residue;
  logic [30:0] o_remaining;

  int checks = 0;
  int errors = 0;

  change_dispense_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_total       (i_total),
    .i_coin_ready  (i_coin_ready),
    .o_coin_valid  (o_coin_valid),
    .o_coin_sel    (o_coin_sel),
    .o_clear_total (o_clear_total),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_residue     (o_residue),
    .o_remaining   (o_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_start = 1'b0; i_total = '0; i_coin_ready = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({o_coin_valid, o_coin_sel, o_clear_total, o_busy, o_done} !== 7'b0) begin
        errors++;
        $display("[TB] FAIL reset_ctrl cycle %0d: got v=%b sel=%b clr=%b busy=%b done=%b, want all 0",
                 c, o_coin_valid, o_coin_sel, o_clear_total, o_busy, o_done);
      end
      checks++;
      if (o_remaining !== 31'd0 || o_residue !== 31'd0) begin
        errors++;
        $display("[TB] FAIL reset_money cycle %0d: got rem=%0d res=%0d, want 0/0", c, o_remaining, o_residue);
      end
      tick();
    end
  endtask

  // Start is sampled on the next edge (edge 0); returns in cycle 1.
  task automatic start_op(input logic [30:0] total);
    i_total = total;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_nominal();
    logic [2:0]  exp_sel [3] = '{3'b100, 3'b010, 3'b001};
    logic [30:0] exp_rem [3] = '{31'd1600, 31'd600, 31'd100};
    i_coin_ready = 1'b1;
    start_op(31'd1600);
    checks++;
    if (o_clear_total !== 1'b1) begin
      errors++; $display("[TB] FAIL nominal_clear: got %b want 1", o_clear_total);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_coin_valid !== 1'b1 || o_coin_sel !== exp_sel[c] || o_remaining !== exp_rem[c]) begin
        errors++;
        $display("[TB] FAIL nominal_coin%0d: got v=%b sel=%b rem=%0d want v=1 sel=%b rem=%0d",
                 c, o_coin_valid, o_coin_sel, o_remaining, exp_sel[c], exp_rem[c]);
      end
      if (c == 1) begin
        checks++;
        if (o_clear_total !== 1'b0) begin
          errors++; $display("[TB] FAIL nominal_clear_pulse: got %b want 0", o_clear_total);
        end
      end
      tick();
    end
    checks++;
    if (o_done !== 1'b1 || o_coin_valid !== 1'b0 || o_coin_sel !== 3'b000 || o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nominal_done: got done=%b v=%b sel=%b busy=%b want 1/0/000/1",
               o_done, o_coin_valid, o_coin_sel, o_busy);
    end
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_residue !== 31'd0 || o_remaining !== 31'd0) begin
      errors++;
      $display("[TB] FAIL nominal_idle: got busy=%b done=%b res=%0d rem=%0d want 0/0/0/0",
               o_busy, o_done, o_residue, o_remaining);
    end
  endtask

  task automatic test_residue();
    logic [2:0]  exp_sel [3] = '{3'b100, 3'b100, 3'b001};
    logic [30:0] exp_rem [3] = '{31'd2150, 31'd1150, 31'd150};
    i_coin_ready = 1'b1;
    start_op(31'd2150);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_coin_valid !== 1'b1 || o_coin_sel !== exp_sel[c] || o_remaining !== exp_rem[c]) begin
        errors++;
        $display("[TB] FAIL residue_coin%0d: got v=%b sel=%b rem=%0d want v=1 sel=%b rem=%0d",
                 c, o_coin_valid, o_coin_sel, o_remaining, exp_sel[c], exp_rem[c]);
      end
      tick();
    end
    checks++;
    if (o_done !== 1'b1 || o_remaining !== 31'd50) begin
      errors++; $display("[TB] FAIL residue_done: got done=%b rem=%0d want 1/50", o_done, o_remaining);
    end
    tick();
    checks++;
    if (o_residue !== 31'd50 || o_remaining !== 31'd50 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL residue_value: got res=%0d rem=%0d busy=%b want 50/50/0", o_residue, o_remaining, o_busy);
    end
  endtask

  task automatic test_backpressure();
    i_coin_ready = 1'b0;
    start_op(31'd500);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (o_coin_valid !== 1'b1 || o_coin_sel !== 3'b010 || o_remaining !== 31'd500) begin
        errors++;
        $display("[TB] FAIL backpressure_hold cycle %0d: got v=%b sel=%b rem=%0d want 1/010/500",
                 c, o_coin_valid, o_coin_sel, o_remaining);
      end
      tick();
    end
    i_coin_ready = 1'b1;
    checks++;
    if (o_coin_valid !== 1'b1 || o_coin_sel !== 3'b010 || o_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_present: got v=%b sel=%b done=%b want 1/010/0", o_coin_valid, o_coin_sel, o_done);
    end
    tick();
    checks++;
    if (o_done !== 1'b1 || o_remaining !== 31'd0) begin
      errors++; $display("[TB] FAIL backpressure_done: got done=%b rem=%0d want 1/0", o_done, o_remaining);
    end
    tick();
  endtask

  task automatic test_zero_and_ignored();
    int coins;
    int dones;
    i_coin_ready = 1'b1;
    start_op(31'd0);
    checks++;
    if (o_done !== 1'b1 || o_coin_valid !== 1'b0 || o_clear_total !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_done: got done=%b v=%b clr=%b busy=%b want 1/0/1/1",
               o_done, o_coin_valid, o_clear_total, o_busy);
    end
    tick();
    checks++;
    if (o_residue !== 31'd0 || o_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_residue: got res=%0d busy=%b want 0/0", o_residue, o_busy);
    end
    // Second start held high through DISPENSE must be ignored.
    i_total = 31'd1100;
    i_start = 1'b1;
    tick();
    i_total = 31'd3000;
    coins = 0;
    dones = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) i_start = 1'b0;
      if (o_coin_valid && i_coin_ready) coins++;
      if (o_done) dones++;
      tick();
    end
    checks++;
    if (coins !== 2) begin
      errors++; $display("[TB] FAIL ignored_start_coins: got %0d want 2", coins);
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("[TB] FAIL ignored_start_done: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    i_coin_ready = 1'b1;
    start_op(31'd3000);
    checks++;
    if (o_coin_sel !== 3'b100 || o_remaining !== 31'd3000) begin
      errors++; $display("[TB] FAIL midreset_first: got sel=%b rem=%0d want 100/3000", o_coin_sel, o_remaining);
    end
    tick();
    checks++;
    if (o_remaining !== 31'd2000 || o_coin_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_second: got rem=%0d v=%b want 2000/1", o_remaining, o_coin_valid);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (o_busy !== 1'b0 || o_coin_valid !== 1'b0 || o_remaining !== 31'd0 || o_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_abort: got busy=%b v=%b rem=%0d done=%b want 0/0/0/0",
               o_busy, o_coin_valid, o_remaining, o_done);
    end
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_done || o_busy) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("[TB] FAIL midreset_quiet: got %0d active cycles want 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_residue();
    test_backpressure();
    test_zero_and_ignored();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
